// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - 16x oversampled UART receiver feeding a first-word-fall-through byte FIFO.
// Optional even-parity frame (8E1) enabled by defining UART_RX_PARITY_EN.
module uart_rx_fifo #(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 8,
    parameter int LED_HOLD   = 2_500_000
) (
    input  logic                          sys_clk_i,
    input  logic                          sys_rst_i,
    input  logic                          uart_rx_i,
    output logic [7:0]                    rx_data_o,
    output logic                          rx_valid_o,
    input  logic                          rx_ready_i,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o,
    output logic                          frame_err_o,
    output logic                          overrun_o,
    output logic                          parity_err_o,
    output logic                          rx_led_o
);

    localparam int TICK_DIV = CLK_FREQ / (BAUD * 16);
    localparam int TW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int PW       = $clog2(FIFO_DEPTH);
    localparam int CW       = PW + 1;
    localparam int LW       = $clog2(LED_HOLD + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    logic            sync1_q, sync1_d;
    logic            sync2_q, sync2_d;
    logic            prev_q, prev_d;
    logic [TW-1:0]   tick_cnt_q, tick_cnt_d;
    logic            tick;
    logic            tick_clr;

    state_t          state_q, state_d;
    logic [3:0]      s_q, s_d;
    logic [2:0]      bit_idx_q, bit_idx_d;
    logic [7:0]      shift_q, shift_d;
    logic            brk_q, brk_d;
    logic            par_bad_q, par_bad_d;
    logic            push_q, push_d;
    logic [7:0]      push_data_q, push_data_d;
    logic            frame_err_q, frame_err_d;
    logic            overrun_q, overrun_d;
    logic            parity_err_d;

    logic [7:0]      mem_q [FIFO_DEPTH];
    logic [7:0]      mem_d [FIFO_DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [LW-1:0]   led_cnt_q, led_cnt_d;
    logic            full, empty, pop, push_ok;

    always_comb begin
        sync1_d    = uart_rx_i;
        sync2_d    = sync1_q;
        prev_d     = sync2_q;
        tick       = (tick_cnt_q == TW'(TICK_DIV - 1));
        tick_cnt_d = (tick_clr || tick) ? '0 : tick_cnt_q + TW'(1);
    end

    // Bit engine: START samples at s=7 (half bit), later bits at s=15 (one full bit on).
    always_comb begin
        state_d      = state_q;
        s_d          = s_q;
        bit_idx_d    = bit_idx_q;
        shift_d      = shift_q;
        brk_d        = brk_q;
        par_bad_d    = par_bad_q;
        push_d       = 1'b0;
        push_data_d  = push_data_q;
        frame_err_d  = 1'b0;
        parity_err_d = 1'b0;
        tick_clr     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (prev_q && !sync2_q) begin
                    state_d   = S_START;
                    s_d       = 4'd0;
                    tick_clr  = 1'b1;
                    par_bad_d = 1'b0;
                    brk_d     = 1'b0;
                end
            end
            S_START: begin
                if (tick) begin
                    if (s_q == 4'd7) begin
                        s_d       = 4'd0;
                        bit_idx_d = 3'd0;
                        state_d   = sync2_q ? S_IDLE : S_DATA;
                    end else begin
                        s_d = s_q + 4'd1;
                    end
                end
            end
            S_DATA: begin
                if (tick) begin
                    if (s_q == 4'd15) begin
                        s_d     = 4'd0;
                        shift_d = {sync2_q, shift_q[7:1]};
                        if (bit_idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            state_d = S_PARITY;
`else
                            state_d = S_STOP;
`endif
                        end else begin
                            bit_idx_d = bit_idx_q + 3'd1;
                        end
                    end else begin
                        s_d = s_q + 4'd1;
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (tick) begin
                    if (s_q == 4'd15) begin
                        s_d     = 4'd0;
                        state_d = S_STOP;
                        if ((^shift_q) ^ sync2_q) begin
                            par_bad_d    = 1'b1;
                            parity_err_d = 1'b1;
                        end
                    end else begin
                        s_d = s_q + 4'd1;
                    end
                end
            end
`endif
            S_STOP: begin
                // A low stop bit holds here until the line releases, so a break is one error.
                if (brk_q) begin
                    if (sync2_q) begin
                        state_d = S_IDLE;
                        brk_d   = 1'b0;
                    end
                end else if (tick) begin
                    if (s_q == 4'd15) begin
                        s_d = 4'd0;
                        if (sync2_q) begin
                            state_d = S_IDLE;
                            if (!par_bad_q) begin
                                push_d      = 1'b1;
                                push_data_d = shift_q;
                            end
                        end else begin
                            frame_err_d = 1'b1;
                            brk_d       = 1'b1;
                        end
                    end else begin
                        s_d = s_q + 4'd1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // FIFO: a simultaneous push and pop is legal even when full.
    always_comb begin
        full      = (count_q == CW'(FIFO_DEPTH));
        empty     = (count_q == '0);
        pop       = !empty && rx_ready_i;
        push_ok   = push_q && (!full || pop);
        overrun_d = push_q && full && !pop;
        mem_d     = mem_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = push_data_q;
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        if (push_ok && !pop) begin
            count_d = count_q + CW'(1);
        end else if (!push_ok && pop) begin
            count_d = count_q - CW'(1);
        end
        if (push_ok) begin
            led_cnt_d = LW'(LED_HOLD);
        end else if (led_cnt_q != '0) begin
            led_cnt_d = led_cnt_q - LW'(1);
        end else begin
            led_cnt_d = led_cnt_q;
        end
    end

    always_ff @(posedge sys_clk_i or negedge sys_rst_i) begin
        if (!sys_rst_i) begin
            sync1_q     <= 1'b1;
            sync2_q     <= 1'b1;
            prev_q      <= 1'b1;
            tick_cnt_q  <= '0;
            state_q     <= S_IDLE;
            s_q         <= 4'd0;
            bit_idx_q   <= 3'd0;
            shift_q     <= 8'h00;
            brk_q       <= 1'b0;
            par_bad_q   <= 1'b0;
            push_q      <= 1'b0;
            push_data_q <= 8'h00;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
            mem_q       <= '{default: 8'h00};
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            led_cnt_q   <= '0;
        end else begin
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            prev_q      <= prev_d;
            tick_cnt_q  <= tick_cnt_d;
            state_q     <= state_d;
            s_q         <= s_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            brk_q       <= brk_d;
            par_bad_q   <= par_bad_d;
            push_q      <= push_d;
            push_data_q <= push_data_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
            mem_q       <= mem_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            led_cnt_q   <= led_cnt_d;
        end
    end

`ifdef UART_RX_PARITY_EN
    logic parity_err_q;
    always_ff @(posedge sys_clk_i or negedge sys_rst_i) begin
        if (!sys_rst_i) begin
            parity_err_q <= 1'b0;
        end else begin
            parity_err_q <= parity_err_d;
        end
    end
    assign parity_err_o = parity_err_q;
`else
    logic unused_parity;
    assign unused_parity = parity_err_d;
    assign parity_err_o  = 1'b0;
`endif

    assign rx_data_o    = mem_q[rd_ptr_q];
    assign rx_valid_o   = !empty;
    assign fifo_count_o = count_q;
    assign frame_err_o  = frame_err_q;
    assign overrun_o    = overrun_q;
    assign rx_led_o     = (led_cnt_q != '0);

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb/tb_uart_rx_fifo.sv - directed scoreboard bench for uart_rx_fifo (TICK_DIV=8, bit=128 clk).
module tb_uart_rx_fifo;

    localparam int BIT = 128;
`ifdef UART_RX_PARITY_EN
    localparam int PUSH_EDGE = 1219 + BIT;
`else
    localparam int PUSH_EDGE = 1219;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       uart;
    logic       ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [3:0] count;
    logic       frame_err, overrun, parity_err, led;

    int n_cmp = 0;
    int n_err = 0;
    int fe_n = 0, ov_n = 0, pe_n = 0;
    int fe_exp = 0, ov_exp = 0, pe_exp = 0;
    logic [7:0] sb[$];

    uart_rx_fifo #(
        .CLK_FREQ(50_000_000), .BAUD(390_625), .FIFO_DEPTH(8), .LED_HOLD(1000)
    ) dut (
        .sys_clk_i(clk), .sys_rst_i(rst_n), .uart_rx_i(uart),
        .rx_data_o(rx_data), .rx_valid_o(rx_valid), .rx_ready_i(ready),
        .fifo_count_o(count), .frame_err_o(frame_err), .overrun_o(overrun),
        .parity_err_o(parity_err), .rx_led_o(led)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_err === 1'b1) fe_n <= fe_n + 1;
        if (overrun === 1'b1) ov_n <= ov_n + 1;
        if (parity_err === 1'b1) pe_n <= pe_n + 1;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input bit bad_par, input int stop_low);
        @(negedge clk);
        uart = 1'b0;
        repeat (BIT) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart = b[i];
            repeat (BIT) @(negedge clk);
        end
`ifdef UART_RX_PARITY_EN
        uart = (^b) ^ bad_par;
        repeat (BIT) @(negedge clk);
`endif
        if (stop_low > 0) begin
            uart = 1'b0;
            repeat (BIT * stop_low) @(negedge clk);
        end
        uart = 1'b1;
        repeat (BIT) @(negedge clk);
    endtask

    // Called at a negedge: compare head against scoreboard, then pop for one cycle.
    task automatic pop_check(input string tag);
        logic [7:0] exp;
        chk({tag, "_valid"}, rx_valid, 1);
        if (sb.size() == 0) begin
            n_cmp++;
            n_err++;
            $error("FAIL %s_sb: observed pop expected none (scoreboard empty)", tag);
        end else begin
            exp = sb.pop_front();
            chk({tag, "_data"}, rx_data, exp);
        end
        ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        ready = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        uart  = 1'b1;
        ready = 1'b0;
        repeat (20) @(negedge clk);
        chk("rst_data", rx_data, 8'h00);
        chk("rst_valid", rx_valid, 0);
        chk("rst_count", count, 0);
        chk("rst_ferr", frame_err, 0);
        chk("rst_ovr", overrun, 0);
        chk("rst_perr", parity_err, 0);
        chk("rst_led", led, 0);
        rst_n = 1'b1;
        repeat (2000) @(negedge clk);
        chk("idle_valid", rx_valid, 0);
        chk("idle_count", count, 0);

        // Single byte, consumer stalled
        send_byte(8'hA5, 0, 0);
        sb.push_back(8'hA5);
        chk("a5_count", count, 1);
        chk("a5_led", led, 1);
        pop_check("a5");
        chk("a5_valid_after", rx_valid, 0);
        chk("a5_count_after", count, 0);
        repeat (1200) @(negedge clk);
        chk("led_expired", led, 0);

        // Start glitch shorter than half a bit
        uart = 1'b0;
        repeat (30) @(negedge clk);
        uart = 1'b1;
        repeat (3 * BIT) @(negedge clk);
        chk("glitch_count", count, 0);
        chk("glitch_fe", fe_n, fe_exp);

        // Stop bit held low for two bits, then a good byte
        send_byte(8'h3C, 0, 2);
        fe_exp++;
        chk("frame_fe", fe_n, fe_exp);
        chk("frame_count", count, 0);
        send_byte(8'h81, 0, 0);
        sb.push_back(8'h81);
        chk("after_frame_count", count, 1);
        pop_check("b81");

        // Fill past capacity
        for (int b = 1; b <= 9; b++) begin
            send_byte(8'(b), 0, 0);
            if (b <= 8) sb.push_back(8'(b));
        end
        ov_exp++;
        chk("full_count", count, 8);
        chk("full_ovr", ov_n, ov_exp);

        // Pop exactly on the cycle the next byte is pushed into the full FIFO
        fork
            send_byte(8'h0A, 0, 0);
            begin
                @(negedge clk);
                repeat (PUSH_EDGE) @(posedge clk);
                @(negedge clk);
                pop_check("pp");
                sb.push_back(8'h0A);
                chk("pp_count", count, 8);
            end
        join
        chk("pp_ovr", ov_n, ov_exp);
        chk("pp_count_end", count, 8);
        for (int i = 0; i < 8; i++) pop_check("drain");
        chk("drain_valid", rx_valid, 0);

        // Reset in the middle of a frame
        send_byte(8'h11, 0, 0);
        chk("pre_rst_count", count, 1);
        fork
            send_byte(8'h22, 0, 0);
            begin
                @(negedge clk);
                repeat (4 * BIT) @(negedge clk);
                rst_n = 1'b0;
                #1;
                chk("midrst_count", count, 0);
                chk("midrst_valid", rx_valid, 0);
            end
        join
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3 * BIT) @(negedge clk);
        chk("postrst_count", count, 0);
        chk("postrst_valid", rx_valid, 0);

`ifdef UART_RX_PARITY_EN
        send_byte(8'h07, 1, 0);
        pe_exp++;
        chk("par_count", count, 0);
        chk("par_fe", fe_n, fe_exp);
`endif
        chk("perr_total", pe_n, pe_exp);
        chk("fe_total", fe_n, fe_exp);
        chk("ovr_total", ov_n, ov_exp);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
